// File: rtl/ped_signal_controller.sv
// Pedestrian crossing lamp controller slaved to an upstream vehicle light controller.
// Serves latched button requests on the vehicle red rise; conflicts latch a sticky fault.
module ped_signal_controller #(
   parameter int unsigned WALK_CYCLES  = 4,
   parameter int unsigned FLASH_CYCLES = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       red,
   input  logic       green,
   input  logic       ped_button,
   output logic [1:0] ped_state,
   output logic       walk,
   output logic       dont_walk,
   output logic       flash,
   output logic [3:0] countdown,
   output logic       pending,
   output logic       fault
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ARMED = 2'b01,
      S_WALK  = 2'b10,
      S_CLEAR = 2'b11
   } state_e;

   state_e             state_q, state_d;
   logic               walk_q, walk_d;
   logic               dont_walk_q, dont_walk_d;
   logic               flash_q, flash_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pending_q, pending_d;
   logic               fault_q, fault_d;
   logic               red_d_q, btn_d_q;

   logic               press_c;
   logic               red_rise_c;
   logic               conflict_c;

   assign press_c    = ped_button & ~btn_d_q;
   assign red_rise_c = red & ~red_d_q;
   assign conflict_c = (red & green) |
                       (green & ((state_q == S_WALK) | (state_q == S_CLEAR)));

   // State and registered outputs; reset forces the idle lamp pattern immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         walk_q      <= 1'b0;
         dont_walk_q <= 1'b1;
         flash_q     <= 1'b0;
         cnt_q       <= '0;
         pending_q   <= 1'b0;
         fault_q     <= 1'b0;
         red_d_q     <= 1'b0;
         btn_d_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         walk_q      <= walk_d;
         dont_walk_q <= dont_walk_d;
         flash_q     <= flash_d;
         cnt_q       <= cnt_d;
         pending_q   <= pending_d;
         fault_q     <= fault_d;
         red_d_q     <= red;
         btn_d_q     <= ped_button;
      end
   end

   // Next-state; a conflict (or a standing fault) overrides every other transition.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      fault_d   = fault_q;

      if (fault_q || conflict_c) begin
         fault_d   = 1'b1;
         state_d   = S_IDLE;
         cnt_d     = '0;
         pending_d = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               cnt_d = '0;
               if (press_c) begin
                  state_d   = S_ARMED;
                  pending_d = 1'b1;
               end
            end
            S_ARMED: begin
               cnt_d = '0;
               if (red_rise_c && !green) begin
                  state_d   = S_WALK;
                  cnt_d     = CNT_W'(WALK_CYCLES);
                  pending_d = 1'b0;
               end
            end
            S_WALK: begin
               pending_d = pending_q | press_c;
               if ((!red && !green) || (cnt_q == CNT_W'(1))) begin
                  state_d = S_CLEAR;
                  cnt_d   = CNT_W'(FLASH_CYCLES);
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            S_CLEAR: begin
               pending_d = pending_q | press_c;
               if (cnt_q == CNT_W'(1)) begin
                  state_d = pending_d ? S_ARMED : S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      walk_d      = (state_d == S_WALK);
      flash_d     = (state_d == S_CLEAR);
      dont_walk_d = ~(walk_d | flash_d);
   end

   assign ped_state = state_q;
   assign walk      = walk_q;
   assign dont_walk = dont_walk_q;
   assign flash     = flash_q;
   assign countdown = cnt_q;
   assign pending   = pending_q;
   assign fault     = fault_q;

endmodule
